// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction word encoder and the decode-stage control unit:
// field geometry, opcode values, immediate-form classification and the encoder FSM states.
package isa_pkg;

    localparam int INSTR_WIDTH    = 32;
    localparam int OPCODE_WIDTH   = 5;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int IMM_WIDTH      = INSTR_WIDTH - OPCODE_WIDTH - 3 * REG_ADDR_WIDTH;
    localparam int ADDR_WIDTH     = 10;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 23;
    localparam int RS1_MSB = 22;
    localparam int RS1_LSB = 19;
    localparam int RS2_MSB = 18;
    localparam int RS2_LSB = 15;
    localparam int IMM_MSB = 14;
    localparam int IMM_LSB = 0;

    typedef logic [OPCODE_WIDTH-1:0]   opcode_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [IMM_WIDTH-1:0]      imm_t;
    typedef logic [INSTR_WIDTH-1:0]    word_t;

    localparam opcode_t OP_NOP = 5'd0;
    localparam opcode_t OP_01  = 5'd1;
    localparam opcode_t OP_02  = 5'd2;
    localparam opcode_t OP_03  = 5'd3;
    localparam opcode_t OP_04  = 5'd4;
    localparam opcode_t OP_05  = 5'd5;
    localparam opcode_t OP_06  = 5'd6;
    localparam opcode_t OP_07  = 5'd7;
    localparam opcode_t OP_08  = 5'd8;
    localparam opcode_t OP_09  = 5'd9;
    localparam opcode_t OP_10  = 5'd10;
    localparam opcode_t OP_11  = 5'd11;
    localparam opcode_t OP_12  = 5'd12;
    localparam opcode_t OP_13  = 5'd13;
    localparam opcode_t OP_14  = 5'd14;
    localparam opcode_t OP_15  = 5'd15;

    // Immediate-form opcodes carry imm and drop rs2.
    function automatic logic is_imm_opcode(input opcode_t op);
        case (op)
            OP_08, OP_12, OP_14, OP_15: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal_opcode(input opcode_t op);
        return ~op[OPCODE_WIDTH-1];
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational field packer: builds a legal 32-bit instruction word from its fields and
// flags illegal opcodes, which are replaced by an all-zero NOP word.
module instr_field_pack
    import isa_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0]   opcode_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_i,
    input  logic [IMM_WIDTH-1:0]      imm_i,
    output logic [INSTR_WIDTH-1:0]    word_o,
    output logic                      illegal_o
);

    // Field packing with sanitising of illegal opcodes and unused fields.
    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        if (!is_legal_opcode(opcode_i)) begin
            illegal_o = 1'b1;
        end else if (opcode_i == OP_NOP) begin
            word_o = '0;
        end else begin
            word_o[OPC_MSB:OPC_LSB] = opcode_i;
            word_o[RD_MSB:RD_LSB]   = rd_i;
            word_o[RS1_MSB:RS1_LSB] = rs1_i;
            if (is_imm_opcode(opcode_i)) begin
                word_o[IMM_MSB:IMM_LSB] = imm_i;
            end else begin
                word_o[RS2_MSB:RS2_LSB] = rs2_i;
            end
        end
    end

endmodule

// File: rtl/instr_word_encoder.sv
// Instruction word encoder: accepts field bundles over valid/ready, packs them and writes the
// resulting words to consecutive instruction-memory addresses from a programmed base.
module instr_word_encoder
    import isa_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [ADDR_WIDTH:0]       count,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPCODE_WIDTH-1:0]   in_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
    input  logic [IMM_WIDTH-1:0]      in_imm,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [INSTR_WIDTH-1:0]    mem_wdata,
    input  logic                      mem_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      error
);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     remaining_q;
    logic [INSTR_WIDTH-1:0]  word_q;
    logic                    in_ready_q;
    logic                    mem_we_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;

    logic [INSTR_WIDTH-1:0]  pack_word_s;
    logic                    pack_illegal_s;

    instr_field_pack u_pack (
        .opcode_i  (in_opcode),
        .rd_i      (in_rd),
        .rs1_i     (in_rs1),
        .rs2_i     (in_rs2),
        .imm_i     (in_imm),
        .word_o    (pack_word_s),
        .illegal_o (pack_illegal_s)
    );

    localparam logic [ADDR_WIDTH:0] REM_ZERO = '0;
    localparam logic [ADDR_WIDTH:0] REM_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Burst FSM; all outputs are registered alongside the state so they change only on clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            word_q      <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    if (start) begin
                        addr_q      <= base_addr;
                        remaining_q <= count;
                        error_q     <= 1'b0;
                        if (count == REM_ZERO) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_ACCEPT;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                ST_ACCEPT: begin
                    if (in_valid && in_ready_q) begin
                        word_q     <= pack_word_s;
                        error_q    <= error_q | pack_illegal_s;
                        in_ready_q <= 1'b0;
                        mem_we_q   <= 1'b1;
                        state_q    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // Address and data stay frozen until memory takes the write.
                    if (mem_ready) begin
                        mem_we_q    <= 1'b0;
                        addr_q      <= addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                        remaining_q <= remaining_q - REM_ONE;
                        if (remaining_q == REM_ONE) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_ACCEPT;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_instr_word_encoder.sv
// Self-checking bench for instr_word_encoder: randomised bursts compared against an
// arithmetic reference of the word format, address sequence and burst timing.
module tb_instr_word_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] count;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [3:0]  in_rd, in_rs1, in_rs2;
    logic [14:0] in_imm;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        busy, done, error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0]  op_a  [16];
    logic [3:0]  rd_a  [16];
    logic [3:0]  rs1_a [16];
    logic [3:0]  rs2_a [16];
    logic [14:0] imm_a [16];

    always #5 clk = ~clk;

    instr_word_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .error(error)
    );

    // Reference word: opcode*2^27 + rd*2^23 + rs1*2^19 + (rs2*2^15 | imm) by opcode class.
    function automatic logic [31:0] model_word(int op, int rd, int rs1, int rs2, int imm);
        longint w;
        bit     imm_form;
        if (op >= 16 || op == 0) return 32'd0;
        imm_form = (op == 8) || (op == 12) || (op == 14) || (op == 15);
        w = longint'(op) * 134217728 + longint'(rd) * 8388608 + longint'(rs1) * 524288;
        if (imm_form) w = w + imm;
        else          w = w + longint'(rs2) * 32768;
        return w[31:0];
    endfunction

    task automatic fill_random(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            op_a[i]  = 5'($urandom_range(0, 31));
            rd_a[i]  = 4'($urandom);
            rs1_a[i] = 4'($urandom);
            rs2_a[i] = 4'($urandom);
            imm_a[i] = 15'($urandom);
        end
    endtask

    task automatic run_burst(input logic [9:0] base, input int cnt, input int stall_first,
                             input bit rand_stall);
        int acc, wr, cyc, stall, total_stall;
        bit exp_err, done_seen;
        logic [9:0]  exp_addr;
        logic [31:0] exp_word;
        exp_err = 1'b0;
        for (int i = 0; i < cnt; i++) if (op_a[i] >= 5'd16) exp_err = 1'b1;
        @(negedge clk);
        start = 1'b1; base_addr = base; count = 11'(cnt);
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++; $display("FAIL err_clear: error=%b required 0", error);
        end
        acc = 0; wr = 0; cyc = 1; stall = stall_first; total_stall = 0; done_seen = 1'b0;
        while (cyc < 400) begin
            if (done) begin done_seen = 1'b1; break; end
            n_tests++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL busy: got %b required 1", busy); end
            if (mem_we) begin
                exp_addr = base + 10'(wr);
                exp_word = model_word(op_a[wr], rd_a[wr], rs1_a[wr], rs2_a[wr], imm_a[wr]);
                n_tests++;
                if (mem_addr !== exp_addr || mem_wdata !== exp_word || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL write%0d: addr=%h data=%h rdy=%b required addr=%h data=%h rdy=0",
                             wr, mem_addr, mem_wdata, in_ready, exp_addr, exp_word);
                end
                if (stall > 0) begin
                    mem_ready = 1'b0; stall--; total_stall++;
                end else begin
                    mem_ready = 1'b1; wr++;
                    stall = rand_stall ? $urandom_range(0, 2) : 0;
                end
            end else begin
                mem_ready = 1'($urandom);
            end
            if (in_ready) begin
                n_tests++;
                if (acc >= cnt) begin
                    n_fail++; $display("FAIL extra_ready: in_ready=1 after %0d bundles", acc);
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1; in_opcode = op_a[acc]; in_rd = rd_a[acc];
                    in_rs1 = rs1_a[acc]; in_rs2 = rs2_a[acc]; in_imm = imm_a[acc];
                    acc++;
                end
            end else begin
                in_valid = 1'($urandom); in_opcode = 5'($urandom); in_rd = 4'($urandom);
                in_rs1 = 4'($urandom); in_rs2 = 4'($urandom); in_imm = 15'($urandom);
            end
            start = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        n_tests++;
        if (!done_seen || wr != cnt || busy !== 1'b0 || error !== exp_err) begin
            n_fail++;
            $display("FAIL burst_end: done=%b writes=%0d busy=%b err=%b required done=1 writes=%0d busy=0 err=%b",
                     done_seen, wr, busy, error, cnt, exp_err);
        end
        if (cnt > 0) begin
            n_tests++;
            if (cyc != 2 * cnt + 1 + total_stall) begin
                n_fail++; $display("FAIL latency: %0d cycles required %0d", cyc, 2 * cnt + 1 + total_stall);
            end
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || mem_we !== 1'b0 || error !== exp_err) begin
            n_fail++;
            $display("FAIL after_done: done=%b busy=%b we=%b err=%b required 0 0 0 %b",
                     done, busy, mem_we, error, exp_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = 10'd0; count = 11'd0; in_valid = 1'b0;
        in_opcode = 5'd0; in_rd = 4'd0; in_rs1 = 4'd0; in_rs2 = 4'd0; in_imm = 15'd0;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, busy, done, error} !== 47'd0) begin
            n_fail++;
            $display("FAIL reset: rdy=%b we=%b addr=%h data=%h busy=%b done=%b err=%b required all 0",
                     in_ready, mem_we, mem_addr, mem_wdata, busy, done, error);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_back_to_back();
        fill_random(3);
        op_a[0] = 5'd10; rd_a[0] = 4'd1; rs1_a[0] = 4'd2; rs2_a[0] = 4'd3; imm_a[0] = 15'h7FFF;
        op_a[1] = 5'd8;  rd_a[1] = 4'd2; rs1_a[1] = 4'd3; rs2_a[1] = 4'd7; imm_a[1] = 15'h1234;
        op_a[2] = 5'd1;
        run_burst(10'h3FE, 3, 0, 1'b0);
    endtask

    task automatic test_illegal();
        fill_random(2);
        op_a[0] = 5'h13; op_a[1] = 5'd5;
        run_burst(10'h040, 2, 0, 1'b0);
        fill_random(1);
        op_a[0] = 5'd3;
        run_burst(10'h100, 1, 0, 1'b0);
    endtask

    task automatic test_stall();
        fill_random(2);
        op_a[0] = 5'd12; op_a[1] = 5'd0;
        run_burst(10'h200, 2, 4, 1'b0);
    endtask

    task automatic test_count_zero();
        run_burst(10'h155, 0, 0, 1'b0);
    endtask

    task automatic test_midwrite_reset();
        int guard;
        fill_random(2);
        op_a[0] = 5'd4;
        @(negedge clk);
        start = 1'b1; base_addr = 10'h010; count = 11'd2;
        @(negedge clk);
        start = 1'b0; mem_ready = 1'b0;
        in_valid = 1'b1; in_opcode = op_a[0]; in_rd = rd_a[0];
        in_rs1 = rs1_a[0]; in_rs2 = rs2_a[0]; in_imm = imm_a[0];
        guard = 0;
        while (!mem_we && guard < 20) begin @(negedge clk); guard++; end
        in_valid = 1'b0;
        n_tests++;
        if (mem_we !== 1'b1) begin n_fail++; $display("FAIL reach_write: mem_we=%b required 1", mem_we); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: we=%b busy=%b rdy=%b done=%b required 0", mem_we, busy, in_ready, done);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        fill_random(1);
        run_burst(10'h020, 1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            int cnt;
            cnt = $urandom_range(1, 6);
            fill_random(cnt);
            run_burst(10'($urandom), cnt, $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_back_to_back();
        test_illegal();
        test_stall();
        test_count_zero();
        test_midwrite_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
